svcs_frame_tx: RTL

SVCS_FRAME_TX -- requirements
Module: svcs_frame_tx

---
 rtl/svcs_frame_tx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/svcs_frame_tx.sv
// svcs_frame_tx -- frame transmitter.
//
// Accepts one frame request (type, element count, payload), checks it, and
// sends it as a stream of DATA_W-bit words: one header word, then
// count*WPE payload words. Element 0 goes first. Within an element, the
// least-significant word goes first. Invalid requests are dropped and pulse
// err for one cycle.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake (ready only in IDLE)
//   in_type[1:0]         0 int, 1 real, 2 vector, 3 reserved (rejected)
//   in_count[7:0]        elements in frame (1..MAX_ELEMS accepted)
//   in_data              MAX_ELEMS*ELEM_W payload; element k at [k*ELEM_W +: ELEM_W]
//   out_valid/out_ready  output word handshake
//   out_data[DATA_W-1:0] header or payload word (0 when out_valid=0)
//   out_last             final payload word of a frame
//   err                  one-cycle pulse after a rejected request
//   frame_cnt[15:0]      completed frames, wraps
module svcs_frame_tx #(
  parameter int         DATA_W    = 32,
  parameter int         ELEM_W    = 64,
  parameter int         MAX_ELEMS = 16,
  parameter logic [7:0] SYNC      = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_type,
  input  logic [7:0]                    in_count,
  input  logic [MAX_ELEMS*ELEM_W-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_last,
  output logic                          err,
  output logic [15:0]                   frame_cnt
);

  localparam int WPE = ELEM_W / DATA_W;        // words per element
  localparam int NW  = MAX_ELEMS * WPE;        // payload words at max count
  localparam int WW  = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   type_q, type_d;
  logic [7:0]                   count_q, count_d;
  // Payload held as a word array so word i of the frame is simply data_q[i].
  logic [NW-1:0][DATA_W-1:0]    data_q, data_d;
  logic [WW-1:0]                widx_q, widx_d;   // current payload word
  logic [WW-1:0]                wlast_q, wlast_d; // index of final payload word
  logic                         err_q, err_d;
  logic [15:0]                  fcnt_q, fcnt_d;

  logic                         accept;
  logic                         bad;
  logic [DATA_W-1:0]            hdr;

  // in_ready is gated by rst_n so it reads 0 for the whole reset window.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign bad       = (in_count == 8'd0) || (int'(in_count) > MAX_ELEMS) ||
                     (in_type == 2'd3);

  assign hdr       = {SYNC, {(DATA_W-18){1'b0}}, type_q, count_q};

  // Outputs decode straight from registered state. They stay stable during a
  // stall and clear at once when reset is asserted.
  assign out_valid = (state_q != IDLE);
  assign out_last  = (state_q == PAY) && (widx_q == wlast_q);
  assign err       = err_q;
  assign frame_cnt = fcnt_q;

  always_comb begin
    out_data = '0;
    case (state_q)
      HDR:     out_data = hdr;
      PAY:     out_data = data_q[widx_q];
      default: out_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    count_d = count_q;
    data_d  = data_q;
    widx_d  = widx_q;
    wlast_d = wlast_q;
    err_d   = 1'b0;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Latch the fields even for a rejected request. Nothing is
          // emitted from IDLE, so the latched values are harmless.
          type_d  = in_type;
          count_d = in_count;
          data_d  = in_data;
          widx_d  = '0;
          wlast_d = WW'(int'(in_count) * WPE - 1);
          if (bad) err_d   = 1'b1;
          else     state_d = HDR;
        end
      end
      HDR: begin
        if (out_ready) state_d = PAY;
      end
      PAY: begin
        if (out_ready) begin
          if (widx_q == wlast_q) begin
            state_d = IDLE;
            fcnt_d  = fcnt_q + 16'd1;
          end else begin
            widx_d  = widx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      type_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      widx_q  <= '0;
      wlast_q <= '0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      count_q <= count_d;
      data_q  <= data_d;
      widx_q  <= widx_d;
      wlast_q <= wlast_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

endmodule
